led_seq_ctrl: RTL
=================

# led_seq_ctrl

Sequencer for the 10-LED bar pattern decoder. Generates the 5-bit pattern index on a prescaled step timebase under start/hold/stop control, with loop, one-shot and optional ping-pong modes. Sits between the board button/switch logic and the index input of the LED pattern decoder. The registered index drives the decoder directly.

## Interface
- `DIV`, 2_500_000: clock cycles per step at speed 0 (≥2); 50 MHz gives 20 steps/s.
- `LAST`, 29: highest index sequenced (1..31); indices 30/31 decode to all-dark.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: level sampled each edge; begins or restarts a sequence.
- `stop` input 1: abort to IDLE; priority over all other inputs.
- `hold` input 1: while high in RUN, freeze index and prescaler.
- `mode` input 2: 0 loop, 1 one-shot, 2 ping-pong, 3 treated as loop; latched at start.
- `speed` input 2: step period = `DIV << speed`; latched at start.
- `idx` output 5: pattern index to the decoder.
- `busy` output 1: high in RUN.
- `step` output 1: one-cycle pulse in the cycle `idx` takes a new value by advancing.
- `done` output 1: one-cycle pulse when a one-shot sequence completes.

## Operation
- Reset: state IDLE, `idx`=0, `busy`=0, `step`=0, `done`=0, prescaler=0, direction=up, latched mode/speed=0.
- Prescaler is 27 bits wide (covers `DIV`×8). A tick occurs when prescaler = (`DIV`<<speed_l)−1; the prescaler then wraps to 0.
- IDLE: `idx`=0. On `start`=1 (and `stop`=0): latch mode/speed, clear prescaler, set direction up, `idx`=0, go to RUN.
- RUN: the prescaler counts while `hold`=0. On a tick, `idx` advances per mode and `step` pulses.
  - Loop: 0,1,…,`LAST`,0,1,…
  - One-shot: 0…`LAST`. On the tick at `LAST`: `idx`=0, `done`=1, go to IDLE.
  - Ping-pong: up to `LAST`, then down to 0, then up. Endpoints are shown once per turn (…`LAST`−1,`LAST`,`LAST`−1…). Direction flips in the same cycle as the endpoint step.
- `hold`=1 in RUN freezes the prescaler, `idx` and direction, and suppresses ticks. `busy` stays 1. `hold` is ignored in IDLE.
- `start`=1 in RUN restarts: same action as from IDLE, with new mode/speed latched. No `step` or `done` pulse is issued.
- `stop`=1 in any state: go to IDLE, `idx`=0, prescaler=0, no `done`. This holds even if `start`, `hold` or a tick occurs in the same cycle.
- `start` and a tick in the same cycle: restart wins, `idx`=0, no `step`.
- `rst` mid-sequence returns all outputs to reset values immediately; the controller does not resume.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `start` sampled at edge N: `busy`=1 and `idx`=0 after edge N. The first advance (`idx`=1, `step`=1) happens after edge N+(`DIV`<<speed).
- Steps are spaced exactly `DIV`<<speed cycles apart, plus any cycles spent with `hold`=1.
- `done` is asserted in the same cycle that `busy` falls and `idx` returns to 0.
- `stop` at edge N: `busy`=0 and `idx`=0 after edge N.

## Configuration
- `LED_SEQ_PINGPONG_EN` defined: mode 2 runs ping-pong as above, using the direction register.
- Not defined: the direction register is removed and mode 2 behaves exactly as loop.

## Test plan
With `DIV`=4 and `LAST`=5:
- Reset, then `start` with mode 0, speed 0 → `idx` sequence 0,1,2,3,4,5,0,1 with 4 cycles between steps, `step` pulsing on each change, `busy`=1 throughout.
- `start` with mode 1, speed 1 → `idx` 0..5 at 8-cycle spacing. On the next tick: `idx`=0, `done` pulses once, `busy`=0. Further ticks produce no change.
- `start` with mode 2 and macro defined → 0,1,2,3,4,5,4,3,2,1,0,1. With the macro undefined → 0..5,0,1.
- `hold`=1 for 10 cycles at `idx`=3 mid-period → `idx` stays 3 and there is no `step`. After release, the remaining period elapses, then `idx`=4.
- `stop`, `start` and a tick in the same cycle at `idx`=4 → IDLE, `idx`=0, `busy`=0, no `step` or `done`. A separate `start` at `idx`=4 → `idx`=0, first step after 4 cycles.
- `rst` asserted asynchronously mid-step at `idx`=2, mode 2 → all outputs 0 immediately. After release, outputs stay 0 until `start`.

Source files
------------

// File: rtl/led_seq_ctrl_if.sv
// Control/status bundle between the button/switch logic and the LED pattern sequencer.
interface led_seq_ctrl_if;
    logic       start;
    logic       stop;
    logic       hold;
    logic [1:0] mode;
    logic [1:0] speed;
    logic [4:0] idx;
    logic       busy;
    logic       step;
    logic       done;

    modport master (
        output start, stop, hold, mode, speed,
        input  idx, busy, step, done
    );

    modport slave (
        input  start, stop, hold, mode, speed,
        output idx, busy, step, done
    );
endinterface

// File: rtl/led_seq_ctrl.sv
// LED bar pattern index sequencer: prescaled step timebase with loop/one-shot/ping-pong modes.
// Define LED_SEQ_PINGPONG_EN to enable ping-pong (mode 2); otherwise mode 2 runs as loop.
module led_seq_ctrl #(
    parameter int unsigned DIV  = 2_500_000,
    parameter int unsigned LAST = 29
) (
    input  logic           clk,
    input  logic           rst,
    led_seq_ctrl_if.slave  bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [4:0]  LAST_IDX = 5'(LAST);
    localparam logic [26:0] DIV_W    = 27'(DIV);

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        step_q, step_d;
    logic        done_q, done_d;
    logic [26:0] presc_q, presc_d;
    logic [1:0]  mode_l_q, mode_l_d;
    logic [1:0]  speed_l_q, speed_l_d;
`ifdef LED_SEQ_PINGPONG_EN
    logic        dir_dn_q, dir_dn_d;
`endif

    logic [26:0] presc_lim;
    logic        tick;

    assign presc_lim = (DIV_W << speed_l_q) - 27'd1;
    assign tick      = (state_q == ST_RUN) && !bus.hold && (presc_q == presc_lim);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        step_d    = 1'b0;
        done_d    = 1'b0;
        presc_d   = presc_q;
        mode_l_d  = mode_l_q;
        speed_l_d = speed_l_q;
`ifdef LED_SEQ_PINGPONG_EN
        dir_dn_d  = dir_dn_q;
`endif

        if (bus.stop) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            presc_d = '0;
        end else if (bus.start) begin
            state_d   = ST_RUN;
            idx_d     = '0;
            presc_d   = '0;
            mode_l_d  = bus.mode;
            speed_l_d = bus.speed;
`ifdef LED_SEQ_PINGPONG_EN
            dir_dn_d  = 1'b0;
`endif
        end else if (state_q == ST_RUN && !bus.hold) begin
            if (tick) begin
                presc_d = '0;
                step_d  = 1'b1;
                case (mode_l_q)
                    2'd1: begin
                        if (idx_q == LAST_IDX) begin
                            // Completion returns to 0 without a step pulse.
                            idx_d   = '0;
                            step_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            idx_d = idx_q + 5'd1;
                        end
                    end
`ifdef LED_SEQ_PINGPONG_EN
                    2'd2: begin
                        // Direction flips on the step that lands on an endpoint.
                        if (!dir_dn_q) begin
                            idx_d = idx_q + 5'd1;
                            if (idx_q + 5'd1 == LAST_IDX) dir_dn_d = 1'b1;
                        end else begin
                            idx_d = idx_q - 5'd1;
                            if (idx_q == 5'd1) dir_dn_d = 1'b0;
                        end
                    end
`endif
                    default: begin
                        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 5'd1;
                    end
                endcase
            end else begin
                presc_d = presc_q + 27'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            step_q    <= 1'b0;
            done_q    <= 1'b0;
            presc_q   <= '0;
            mode_l_q  <= '0;
            speed_l_q <= '0;
`ifdef LED_SEQ_PINGPONG_EN
            dir_dn_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            step_q    <= step_d;
            done_q    <= done_d;
            presc_q   <= presc_d;
            mode_l_q  <= mode_l_d;
            speed_l_q <= speed_l_d;
`ifdef LED_SEQ_PINGPONG_EN
            dir_dn_q  <= dir_dn_d;
`endif
        end
    end

    assign bus.idx  = idx_q;
    assign bus.busy = (state_q == ST_RUN);
    assign bus.step = step_q;
    assign bus.done = done_q;

endmodule
